// File: rtl/i2c_cond_gen.sv
// i2c_cond_gen -- I2C START / repeated-START / STOP condition generator.
//
// Drives open-drain style SDA/SCL enables (1 = release, 0 = pull low) and
// spaces every drive change by a quarter SCL period Q = CLK_FREQ/(4*I2C_FREQ)
// system clocks. Supports slave clock stretching and arbitration-loss detection.
//
// Build option: define I2C_COND_STRETCH_TIMEOUT_EN to abort a clock stretch that
// lasts STRETCH_LIMIT cycles (o_timeout pulse). Without it a stretch waits forever
// and o_timeout is tied low.
//
// Ports:
//   i_clk, i_rst               clock, asynchronous active-high reset
//   i_enable, i_req, i_cmd     enable, request, command (00 START, 01 RESTART, 10 STOP)
//   o_ready                    idle and bus not showing SDA low / SCL high
//   o_done                     one-cycle completion pulse
//   o_arb_lost, o_timeout      one-cycle status pulses, coincident with o_done
//   i_sda, i_scl               sampled bus levels
//   o_sda_drive, o_scl_drive   line drive enables (1 = release, 0 = pull low)
module i2c_cond_gen #(
    parameter int unsigned CLK_FREQ      = 25_000_000,
    parameter int unsigned I2C_FREQ      = 100_000,
    parameter int unsigned STRETCH_LIMIT = 25_000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_enable,
    input  logic       i_req,
    input  logic [1:0] i_cmd,
    output logic       o_ready,
    output logic       o_done,
    output logic       o_arb_lost,
    output logic       o_timeout,
    input  logic       i_sda,
    input  logic       i_scl,
    output logic       o_sda_drive,
    output logic       o_scl_drive
);

    localparam int unsigned Q  = CLK_FREQ / (4 * I2C_FREQ);
    localparam int unsigned CW = $clog2(Q + 1);
    localparam logic [CW-1:0] Q_LOAD = CW'(Q - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SDA_HI, S_SCL_HI, S_STRETCH, S_SDA_LO, S_SCL_LO, S_WAIT, S_DONE
    } state_t;

    typedef enum logic [1:0] {
        CMD_START   = 2'b00,
        CMD_RESTART = 2'b01,
        CMD_STOP    = 2'b10
    } cmd_t;

    state_t        state_q, state_d;
    state_t        step_q, step_d;      // last drive step, selects the step after WAIT
    cmd_t          cmd_q, cmd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sda_q, sda_d;
    logic          scl_q, scl_d;
    logic          arb_q, arb_d;

    logic          enter;
    state_t        enter_st;
    logic          abort;

`ifdef I2C_COND_STRETCH_TIMEOUT_EN
    localparam int unsigned SW = $clog2(STRETCH_LIMIT + 1);
    localparam logic [SW-1:0] STR_END = SW'(STRETCH_LIMIT - 1);
    logic [SW-1:0] str_q, str_d;
    logic          tmo_q, tmo_d;
`endif

    assign o_ready     = (state_q == S_IDLE) && !(!i_sda && i_scl);
    assign o_done      = (state_q == S_DONE);
    assign o_arb_lost  = arb_q;
    assign o_sda_drive = sda_q;
    assign o_scl_drive = scl_q;
`ifdef I2C_COND_STRETCH_TIMEOUT_EN
    assign o_timeout   = tmo_q;
`else
    assign o_timeout   = 1'b0;
`endif

    // The counter is loaded with Q-1 on the edge that changes a drive and keeps
    // counting through the one-cycle drive state, so consecutive drive changes
    // are exactly Q cycles apart. Across SCL_HI/STRETCH it only counts while SCL
    // is seen high, so the SCL-high quarter starts when a stretching slave lets go.
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        cmd_d    = cmd_q;
        cnt_d    = cnt_q;
        sda_d    = sda_q;
        scl_d    = scl_q;
        arb_d    = 1'b0;
        enter    = 1'b0;
        enter_st = S_IDLE;
        abort    = 1'b0;
`ifdef I2C_COND_STRETCH_TIMEOUT_EN
        str_d    = '0;
        tmo_d    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_enable) begin
                    sda_d = i_sda;
                    scl_d = i_scl;
                    if (i_req && o_ready && (i_cmd != 2'b11)) begin
                        enter = 1'b1;
                        if (i_cmd == 2'b10) begin
                            cmd_d    = CMD_STOP;
                            enter_st = S_SDA_LO;
                        end else if ((i_cmd == 2'b00) && i_scl) begin
                            cmd_d    = CMD_START;
                            enter_st = S_SDA_LO;
                        end else begin
                            // START with SCL already low needs the repeated-START shape
                            cmd_d    = CMD_RESTART;
                            enter_st = S_SDA_HI;
                        end
                    end
                end
            end
            S_SDA_HI, S_SDA_LO, S_SCL_LO: begin
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                state_d = S_WAIT;
            end
            S_SCL_HI: begin
                if (i_scl && (cnt_q != '0)) cnt_d = cnt_q - 1'b1;
                state_d = S_STRETCH;
            end
            S_STRETCH: begin
                if (i_scl) begin
                    if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                    state_d = S_WAIT;
                end
`ifdef I2C_COND_STRETCH_TIMEOUT_EN
                else if (str_q == STR_END) begin
                    abort = 1'b1;
                    tmo_d = 1'b1;
                end else begin
                    str_d = str_q + 1'b1;
                end
`endif
            end
            S_WAIT: begin
                // SDA is only released by us after an SDA_HI step, so this
                // covers exactly the waits that follow SDA_HI.
                if (sda_q && i_scl && !i_sda) begin
                    abort = 1'b1;
                    arb_d = 1'b1;
                end else if (cnt_q == '0) begin
                    case (step_q)
                        S_SDA_HI: begin
                            if (cmd_q == CMD_STOP) begin
                                state_d = S_DONE;
                            end else begin
                                enter    = 1'b1;
                                enter_st = S_SCL_HI;
                            end
                        end
                        S_SCL_HI: begin
                            enter    = 1'b1;
                            enter_st = (cmd_q == CMD_STOP) ? S_SDA_HI : S_SDA_LO;
                        end
                        S_SDA_LO: begin
                            enter    = 1'b1;
                            enter_st = (cmd_q == CMD_STOP) ? S_SCL_HI : S_SCL_LO;
                        end
                        default: state_d = S_DONE;
                    endcase
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d = S_DONE;
            sda_d   = 1'b1;
            scl_d   = 1'b1;
        end

        if (enter) begin
            state_d = enter_st;
            step_d  = enter_st;
            cnt_d   = Q_LOAD;
            case (enter_st)
                S_SDA_HI: sda_d = 1'b1;
                S_SDA_LO: sda_d = 1'b0;
                S_SCL_HI: scl_d = 1'b1;
                S_SCL_LO: scl_d = 1'b0;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            step_q  <= S_IDLE;
            cmd_q   <= CMD_START;
            cnt_q   <= '0;
            sda_q   <= 1'b1;
            scl_q   <= 1'b1;
            arb_q   <= 1'b0;
`ifdef I2C_COND_STRETCH_TIMEOUT_EN
            str_q   <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cmd_q   <= cmd_d;
            cnt_q   <= cnt_d;
            sda_q   <= sda_d;
            scl_q   <= scl_d;
            arb_q   <= arb_d;
`ifdef I2C_COND_STRETCH_TIMEOUT_EN
            str_q   <= str_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

endmodule

// File: tb/tb_i2c_cond_gen.sv
// tb_i2c_cond_gen -- self-checking bench for i2c_cond_gen (Q = 62, STRETCH_LIMIT = 100).
// Bus lines follow the DUT drives unless the bench forces a level (slave stretch,
// foreign master pulling SDA). Drive edges and done/status pulses are matched
// against a queue of expected events stamped with the expected clock edge count.
module tb_i2c_cond_gen;

    localparam int unsigned Q   = 62;
    localparam int unsigned LIM = 100;

    logic       clk = 1'b0;
    logic       rst, en, req;
    logic [1:0] cmd;
    logic       o_ready, o_done, o_arb_lost, o_timeout;
    logic       o_sda_drive, o_scl_drive;
    logic       sda_frc, sda_fv, scl_frc, scl_fv;
    logic       bus_sda, bus_scl;

    assign bus_sda = sda_frc ? sda_fv : o_sda_drive;
    assign bus_scl = scl_frc ? scl_fv : o_scl_drive;

    always #5 clk = ~clk;

    i2c_cond_gen #(
        .CLK_FREQ     (25_000_000),
        .I2C_FREQ     (100_000),
        .STRETCH_LIMIT(LIM)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_enable   (en),
        .i_req      (req),
        .i_cmd      (cmd),
        .o_ready    (o_ready),
        .o_done     (o_done),
        .o_arb_lost (o_arb_lost),
        .o_timeout  (o_timeout),
        .i_sda      (bus_sda),
        .i_scl      (bus_scl),
        .o_sda_drive(o_sda_drive),
        .o_scl_drive(o_scl_drive)
    );

    // kind: 0 = SDA drive edge, 1 = SCL drive edge, 2 = status {done, arb, tmo}
    typedef struct {
        int unsigned kind;
        logic [2:0]  val;
        int unsigned cyc;
    } ev_t;

    typedef struct {
        logic       en, sda, scl, req;
        logic [1:0] cmd;
        logic       exp_ready, exp_sda, exp_scl;
    } row_t;

    ev_t         sb_q[$];
    row_t        rows[6];
    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned cyc   = 0;
    logic        mon_en = 1'b0;
    logic        p_sda = 1'b1, p_scl = 1'b1;

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic sb_push(input int unsigned k, input logic [2:0] v, input int unsigned c);
        ev_t e;
        e.kind = k; e.val = v; e.cyc = c;
        sb_q.push_back(e);
    endtask

    task automatic observe(input int unsigned k, input logic [2:0] v);
        ev_t e;
        tests++;
        if (sb_q.size() == 0) begin
            fails++;
            $display("FAIL sb_unexpected: kind=%0d val=%b at cycle %0d, none expected", k, v, cyc);
        end else begin
            e = sb_q.pop_front();
            if (e.kind != k || e.val !== v || e.cyc != cyc) begin
                fails++;
                $display("FAIL sb_event: got kind=%0d val=%b cycle=%0d expected kind=%0d val=%b cycle=%0d",
                         k, v, cyc, e.kind, e.val, e.cyc);
            end
        end
    endtask

    // One clock: wait for the falling edge, then compare any output events.
    task automatic tick();
        ev_t e;
        @(negedge clk);
        cyc++;
        if (mon_en) begin
            if (o_sda_drive !== p_sda) observe(0, {2'b00, o_sda_drive});
            if (o_scl_drive !== p_scl) observe(1, {2'b00, o_scl_drive});
            if (o_done || o_arb_lost || o_timeout) observe(2, {o_done, o_arb_lost, o_timeout});
            while (sb_q.size() != 0 && sb_q[0].cyc < cyc) begin
                e = sb_q.pop_front();
                tests++;
                fails++;
                $display("FAIL sb_missing: got nothing expected kind=%0d val=%b cycle=%0d", e.kind, e.val, e.cyc);
            end
        end
        p_sda = o_sda_drive;
        p_scl = o_scl_drive;
    endtask

    task automatic wait_sb(input int unsigned budget);
        for (int unsigned i = 0; i < budget && sb_q.size() != 0; i++) tick();
        if (sb_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL sb_drain: got %0d events pending expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic issue(input logic [1:0] c);
        req = 1'b1;
        cmd = c;
        tick();
        req = 1'b0;
        cmd = 2'b11;
    endtask

    task automatic run_start();
        int unsigned n;
        n = cyc;
        sb_push(0, 3'b000, n + 1);
        sb_push(1, 3'b000, n + 1 + Q);
        sb_push(2, 3'b100, n + 1 + 2 * Q);
        issue(2'b00);
        wait_sb(3 * Q);
        tick();
        check("start_lines", {1'b0, o_sda_drive, o_scl_drive}, 3'b000);
    endtask

    task automatic run_restart(input logic [1:0] c);
        int unsigned n;
        n = cyc;
        sb_push(0, 3'b001, n + 1);
        sb_push(1, 3'b001, n + 1 + Q);
        sb_push(0, 3'b000, n + 1 + 2 * Q);
        sb_push(1, 3'b000, n + 1 + 3 * Q);
        sb_push(2, 3'b100, n + 1 + 4 * Q);
        issue(c);
        wait_sb(5 * Q);
        tick();
        check("restart_lines", {1'b0, o_sda_drive, o_scl_drive}, 3'b000);
    endtask

    initial begin
        int unsigned n, a, r, dcount;

        rows[0] = '{en: 1'b1, sda: 1'b0, scl: 1'b1, req: 1'b1, cmd: 2'b00, exp_ready: 1'b0, exp_sda: 1'b0, exp_scl: 1'b1};
        rows[1] = '{en: 1'b1, sda: 1'b1, scl: 1'b1, req: 1'b1, cmd: 2'b11, exp_ready: 1'b1, exp_sda: 1'b1, exp_scl: 1'b1};
        rows[2] = '{en: 1'b0, sda: 1'b1, scl: 1'b1, req: 1'b1, cmd: 2'b00, exp_ready: 1'b1, exp_sda: 1'b1, exp_scl: 1'b1};
        rows[3] = '{en: 1'b0, sda: 1'b0, scl: 1'b0, req: 1'b0, cmd: 2'b00, exp_ready: 1'b1, exp_sda: 1'b1, exp_scl: 1'b1};
        rows[4] = '{en: 1'b1, sda: 1'b1, scl: 1'b0, req: 1'b0, cmd: 2'b00, exp_ready: 1'b1, exp_sda: 1'b1, exp_scl: 1'b0};
        rows[5] = '{en: 1'b1, sda: 1'b0, scl: 1'b0, req: 1'b0, cmd: 2'b10, exp_ready: 1'b1, exp_sda: 1'b0, exp_scl: 1'b0};

        rst = 1'b1; en = 1'b0; req = 1'b0; cmd = 2'b11;
        sda_frc = 1'b0; sda_fv = 1'b1; scl_frc = 1'b0; scl_fv = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_drives", {1'b0, o_sda_drive, o_scl_drive}, 3'b011);
        check("rst_pulses", {o_done, o_arb_lost, o_timeout}, 3'b000);
        check("rst_ready", {2'b00, o_ready}, 3'b001);
        rst = 1'b0;
        tick();

        // Ready / acceptance / drive-copy table
        for (int i = 0; i < 6; i++) begin
            en = rows[i].en; req = rows[i].req; cmd = rows[i].cmd;
            sda_frc = 1'b1; sda_fv = rows[i].sda;
            scl_frc = 1'b1; scl_fv = rows[i].scl;
            #1;
            check($sformatf("row%0d_ready", i), {2'b00, o_ready}, {2'b00, rows[i].exp_ready});
            tick();
            req = 1'b0; cmd = 2'b11;
            check($sformatf("row%0d_drives", i), {1'b0, o_sda_drive, o_scl_drive},
                  {1'b0, rows[i].exp_sda, rows[i].exp_scl});
            en = 1'b1; sda_fv = 1'b1; scl_fv = 1'b1;
            tick();
            sda_frc = 1'b0; scl_frc = 1'b0;
            #1;
            check($sformatf("row%0d_idle", i), {o_ready, o_sda_drive, o_scl_drive}, 3'b111);
        end

        mon_en = 1'b1;
        tick();

        // START from idle bus, RESTART by command and by START with SCL low
        run_start();
        run_restart(2'b01);
        run_restart(2'b00);

        // STOP with slave holding SCL low for 500 cycles
        scl_frc = 1'b1; scl_fv = 1'b0;
        n = cyc;
        sb_push(1, 3'b001, n + 1 + Q);
        issue(2'b10);
        while (cyc < n + 1 + Q + 250) tick();
        check("stop_stretch_sda", {2'b00, o_sda_drive}, 3'b000);
        while (cyc < n + 1 + Q + 500) tick();
        scl_frc = 1'b0;
        r = cyc;
        sb_push(0, 3'b001, r + Q);
        sb_push(2, 3'b100, r + 2 * Q);
        wait_sb(3 * Q);
        tick();
        check("stop_lines", {1'b0, o_sda_drive, o_scl_drive}, 3'b011);

        // Arbitration loss during the SCL-high wait of a RESTART
        run_start();
        n = cyc;
        a = n + 1 + Q;
        sb_push(0, 3'b001, n + 1);
        sb_push(1, 3'b001, a);
        sb_push(2, 3'b110, a + 11);
        issue(2'b01);
        while (cyc < a + 10) tick();
        sda_frc = 1'b1; sda_fv = 1'b0;
        tick();
        sda_frc = 1'b0;
        check("arb_pulses", {o_done, o_arb_lost, o_timeout}, 3'b110);
        check("arb_drives", {1'b0, o_sda_drive, o_scl_drive}, 3'b011);
        tick();
        check("arb_idle", {o_ready, o_done, o_arb_lost}, 3'b100);
        wait_sb(5);

        // Reset in the middle of a START
        mon_en = 1'b0;
        n = cyc;
        issue(2'b00);
        while (cyc < n + 11) tick();
        check("mid_start_sda", {2'b00, o_sda_drive}, 3'b000);
        rst = 1'b1;
        #1;
        check("mid_rst_drives", {1'b0, o_sda_drive, o_scl_drive}, 3'b011);
        check("mid_rst_done", {2'b00, o_done}, 3'b000);
        tick();
        tick();
        rst = 1'b0;
        dcount = 0;
        for (int unsigned i = 0; i < 3 * Q; i++) begin
            tick();
            if (o_done) dcount++;
        end
        check("mid_rst_no_done", dcount[2:0], 3'b000);
        check("mid_rst_ready", {o_ready, o_sda_drive, o_scl_drive}, 3'b111);
        mon_en = 1'b1;

        // STOP with SCL held low indefinitely
        run_start();
        scl_frc = 1'b1; scl_fv = 1'b0;
        n = cyc;
        a = n + 1 + Q;
        sb_push(1, 3'b001, a);
`ifdef I2C_COND_STRETCH_TIMEOUT_EN
        sb_push(0, 3'b001, a + 1 + LIM);
        sb_push(2, 3'b101, a + 1 + LIM);
        issue(2'b10);
        while (cyc < a + 1 + LIM) tick();
        scl_frc = 1'b0;
        check("tmo_pulses", {o_done, o_arb_lost, o_timeout}, 3'b101);
        check("tmo_drives", {1'b0, o_sda_drive, o_scl_drive}, 3'b011);
        wait_sb(5);
`else
        issue(2'b10);
        dcount = 0;
        while (cyc < a + 10_000) begin
            tick();
            if (o_done || o_timeout) dcount++;
        end
        check("no_tmo_pulse", dcount[2:0], 3'b000);
        scl_frc = 1'b0;
        r = cyc;
        sb_push(0, 3'b001, r + Q);
        sb_push(2, 3'b100, r + 2 * Q);
        wait_sb(3 * Q);
`endif
        tick();
        check("final_lines", {o_ready, o_sda_drive, o_scl_drive}, 3'b111);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/i2c_cond_gen.md
I2C_COND_GEN -- requirements
Module: i2c_cond_gen

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 25_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter I2C_FREQ, default 100_000, SCL frequency in Hz; quarter period Q = CLK_FREQ/(4*I2C_FREQ) cycles, Q >= 2.
REQ-003 SHALL have parameter STRETCH_LIMIT, default 25_000, maximum clock-stretch wait in cycles (used only per REQ-030).
REQ-004 SHALL have port i_clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port i_enable, input, 1, block enable.
REQ-007 SHALL have port i_req, input, 1, command request.
REQ-008 SHALL have port i_cmd, input, 2, command: 00 START, 01 RESTART, 10 STOP, 11 reserved.
REQ-009 SHALL have port o_ready, output, 1, command accept strobe qualifier.
REQ-010 SHALL have port o_done, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port o_arb_lost, output, 1, one-cycle pulse, coincident with o_done.
REQ-012 SHALL have port o_timeout, output, 1, one-cycle pulse, coincident with o_done.
REQ-013 SHALL have ports i_sda and i_scl, input, 1 each, sampled bus levels.
REQ-014 SHALL have ports o_sda_drive and o_scl_drive, output, 1 each; 1 = release (high), 0 = pull low.

Function
REQ-015 o_ready SHALL equal (state==IDLE) & ~(i_sda==0 & i_scl==1).
REQ-016 A command SHALL be accepted on a cycle with i_enable & i_req & o_ready & i_cmd!=11; i_cmd is registered at acceptance; i_cmd==11 is ignored.
REQ-017 In IDLE with i_enable high, drive registers SHALL copy i_sda/i_scl each cycle; with i_enable low they hold.
REQ-018 States: IDLE, SDA_HI, SCL_HI, STRETCH, SDA_LO, SCL_LO, WAIT, DONE; every drive change is followed by WAIT of exactly Q cycles before the next step.
REQ-019 START with i_scl==1 at acceptance: SDA_LO, WAIT, SCL_LO, WAIT, DONE.
REQ-020 START with i_scl==0 at acceptance SHALL execute the RESTART sequence.
REQ-021 RESTART: SDA_HI, WAIT, SCL_HI, STRETCH, WAIT, SDA_LO, WAIT, SCL_LO, WAIT, DONE.
REQ-022 STOP: SDA_LO, WAIT, SCL_HI, STRETCH, WAIT, SDA_HI, WAIT, DONE; ends with both drives released.
REQ-023 STRETCH SHALL hold while i_scl==0 (slave stretching) and advance on the first cycle i_scl==1.
REQ-024 Arbitration: if in any WAIT following SDA_HI the bus shows o_sda_drive==1, i_scl==1, i_sda==0, the block SHALL release both drives, go to DONE, and pulse o_arb_lost with o_done.
REQ-025 DONE SHALL last one cycle, assert o_done, then return to IDLE.
REQ-026 i_req, i_cmd and i_enable SHALL be ignored outside IDLE; deasserting i_enable mid-sequence does not abort it.
REQ-027 Wait counter width SHALL be $clog2(Q+1) bits; no wrap: counter loads Q-1 and decrements to 0.

Reset
REQ-028 On i_rst high, immediately and asynchronously: state IDLE, o_sda_drive=1, o_scl_drive=1, o_done=0, o_arb_lost=0, o_timeout=0, counters 0; reset mid-sequence aborts it with lines released.

Configuration
REQ-029 Macro I2C_COND_STRETCH_TIMEOUT_EN SHALL gate the stretch timeout feature.
REQ-030 With I2C_COND_STRETCH_TIMEOUT_EN defined: a stretch counter ($clog2(STRETCH_LIMIT+1) bits) counts cycles in STRETCH; after STRETCH_LIMIT cycles with i_scl==0 the block releases both drives, goes to DONE, pulses o_timeout with o_done.
REQ-031 Without it: STRETCH waits indefinitely, o_timeout tied 0, no stretch counter exists.

Verification (CLK_FREQ=25_000_000, I2C_FREQ=100_000, Q=62)
REQ-032 Bus idle (1/1), START -> SDA low at accept+1, SCL low 62 cycles later, o_done pulse 62 cycles after that, o_arb_lost=0.
REQ-033 Bus held 0/0 after START, RESTART -> SDA high, +62 SCL high, +62 SDA low, +62 SCL low, +62 o_done; lines end 0/0.
REQ-034 STOP with slave holding i_scl low 500 cycles after SCL_HI -> SDA stays low throughout stretch, SCL-high WAIT starts after release, SDA rises 62 cycles later, o_done, lines end 1/1.
REQ-035 RESTART with external i_sda forced 0 during SCL-high WAIT -> o_arb_lost and o_done pulse same cycle, both drives 1, state IDLE next cycle.
REQ-036 i_sda=0, i_scl=1 with i_req=1 -> o_ready=0, no acceptance; i_rst asserted mid-START -> drives 1/1 same cycle, o_done never pulses.
REQ-037 With macro defined, STRETCH_LIMIT=100, i_scl held 0 in STRETCH -> o_timeout and o_done pulse after 100 cycles, drives 1/1; without macro, no pulse after 10_000 cycles.
